// File: rtl/uart_digit_frame_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_digit_frame_parser_if
//  Description : Bundle between the UART receiver, the digit frame parser and
//                the 7-segment display stage.
//                  rx_data   [7:0]  byte from the UART receiver
//                  rx_busy          receiver busy flag (falling edge = new byte)
//                  digit_id  [5:0]  last accepted digit ID (held)
//                  id_valid         one-cycle pulse when digit_id updates
//                  frame_err        one-cycle pulse on a rejected frame
//                  err_count [7:0]  saturating rejected-frame count
//                  state     [1:0]  parser state (0 IDLE, 1 GOT_SYNC, 2 GOT_ID)
//                master : receiver / stimulus side
//                slave  : parser side
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_digit_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic [5:0] digit_id;
    logic       id_valid;
    logic       frame_err;
    logic [7:0] err_count;
    logic [1:0] state;

    modport master (
        output rx_data,
        output rx_busy,
        input  digit_id,
        input  id_valid,
        input  frame_err,
        input  err_count,
        input  state
    );

    modport slave (
        input  rx_data,
        input  rx_busy,
        output digit_id,
        output id_valid,
        output frame_err,
        output err_count,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/uart_digit_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_digit_frame_parser
//  Description : Assembles 3-byte command frames (SYNC, ID, CHECK) from the
//                UART receiver byte stream, validates them and presents a held
//                6-bit digit ID plus a one-cycle update strobe to the display
//                stage. Rejected or stalled frames pulse frame_err and bump a
//                saturating error counter.
//  Ports       : clk     system clock, rising edge
//                nRESET  asynchronous, active-low reset
//                bus     uart_digit_frame_parser_if.slave
//                          in : rx_data, rx_busy
//                          out: digit_id, id_valid, frame_err, err_count, state
//  Parameters  : REVERSE_BITS   1 = bit-reverse each received byte first
//                TIMEOUT_CYCLES clocks allowed between bytes inside a frame
//                SYNC_BYTE      frame start marker
//                MAX_ID         highest legal ID (range check builds only)
//  Build macro : ID_RANGE_CHECK_EN - when defined, IDs above MAX_ID are
//                rejected in GOT_SYNC like a byte with non-zero upper bits.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_digit_frame_parser #(
    parameter int         REVERSE_BITS   = 1,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_ID         = 35
) (
    input  logic                     clk,
    input  logic                     nRESET,
    uart_digit_frame_parser_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_GOT_SYNC = 2'd1;
    localparam logic [1:0] c_ST_GOT_ID   = 2'd2;

    // Counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int                  c_TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_ONE  = c_TMO_W'(1);

    logic [1:0]         r_state;
    logic               r_busy_q;
    logic [5:0]         r_id_tmp;
    logic [5:0]         r_digit_id;
    logic               r_id_valid;
    logic               r_frame_err;
    logic [7:0]         r_err_count;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    logic [7:0]         w_byte;
    logic               w_byte_stb;
    logic               w_is_sync;
    logic               w_id_bad;
    logic               w_check_ok;
    logic               w_tmo;
    logic [7:0]         w_err_count_inc;

    // The receiver shifts LSB-first, so its byte may arrive mirrored.
    generate
        if (REVERSE_BITS != 0) begin : g_rev
            for (genvar i = 0; i < 8; i++) begin : g_bit
                assign w_byte[i] = bus.rx_data[7-i];
            end
        end else begin : g_norev
            assign w_byte = bus.rx_data;
        end
    endgenerate

    // A new byte is signalled only by the busy 1->0 edge; a held-low busy
    // or data wiggling while busy is high produces nothing.
    assign w_byte_stb = r_busy_q & ~bus.rx_busy;
    assign w_is_sync  = (w_byte == SYNC_BYTE);
    assign w_check_ok = (w_byte == ~{2'b00, r_id_tmp});
    assign w_tmo      = (r_tmo_cnt == c_TMO_LAST);

`ifdef ID_RANGE_CHECK_EN
    assign w_id_bad = (w_byte[7:6] != 2'b00) || (32'(w_byte[5:0]) > 32'(MAX_ID));
`else
    assign w_id_bad = (w_byte[7:6] != 2'b00);
`endif

    assign w_err_count_inc = (r_err_count == 8'hFF) ? 8'hFF : (r_err_count + 8'd1);

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= c_ST_IDLE;
            r_busy_q    <= 1'b0;
            r_id_tmp    <= 6'd0;
            r_digit_id  <= 6'd0;
            r_id_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
            r_tmo_cnt   <= '0;
        end else begin
            r_busy_q    <= bus.rx_busy;
            r_id_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_byte_stb || (r_state == c_ST_IDLE)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    // Anything but SYNC is line noise between frames.
                    if (w_byte_stb && w_is_sync) begin
                        r_state <= c_ST_GOT_SYNC;
                    end
                end

                c_ST_GOT_SYNC: begin
                    // A byte arriving in the timeout cycle takes priority.
                    if (w_byte_stb) begin
                        if (w_is_sync) begin
                            r_state <= c_ST_GOT_SYNC;
                        end else if (w_id_bad) begin
                            r_frame_err <= 1'b1;
                            r_err_count <= w_err_count_inc;
                            r_state     <= c_ST_IDLE;
                        end else begin
                            r_id_tmp <= w_byte[5:0];
                            r_state  <= c_ST_GOT_ID;
                        end
                    end else if (w_tmo) begin
                        r_frame_err <= 1'b1;
                        r_err_count <= w_err_count_inc;
                        r_state     <= c_ST_IDLE;
                        r_tmo_cnt   <= '0;
                    end
                end

                c_ST_GOT_ID: begin
                    if (w_byte_stb) begin
                        if (w_check_ok) begin
                            r_digit_id <= r_id_tmp;
                            r_id_valid <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_count <= w_err_count_inc;
                            // A SYNC in the check slot starts the next frame.
                            r_state     <= w_is_sync ? c_ST_GOT_SYNC : c_ST_IDLE;
                        end
                    end else if (w_tmo) begin
                        r_frame_err <= 1'b1;
                        r_err_count <= w_err_count_inc;
                        r_state     <= c_ST_IDLE;
                        r_tmo_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.digit_id  = r_digit_id;
    assign bus.id_valid  = r_id_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.err_count = r_err_count;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_digit_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_digit_frame_parser
//  Description : Directed self-checking bench for uart_digit_frame_parser.
//                Bytes are given as post-reversal values and mirrored here
//                before driving rx_data. TIMEOUT_CYCLES is set to 16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_digit_frame_parser;

    logic clk;
    logic nRESET;
    int   checks;
    int   errors;
    int   n_valid;
    int   n_err;

    uart_digit_frame_parser_if bus ();

    uart_digit_frame_parser #(
        .REVERSE_BITS   (1),
        .TIMEOUT_CYCLES (16),
        .SYNC_BYTE      (8'hA5),
        .MAX_ID         (35)
    ) dut (
        .clk    (clk),
        .nRESET (nRESET),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: sampled at posedge, i.e. the value of the cycle ending.
    initial begin
        n_valid = 0;
        n_err   = 0;
    end
    always @(posedge clk) begin
        if (bus.id_valid === 1'b1)  n_valid++;
        if (bus.frame_err === 1'b1) n_err++;
    end

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return rev8_ret(r);
    endfunction

    function automatic logic [7:0] rev8_ret(input logic [7:0] r);
        return r;
    endfunction

    // Busy high for two cycles (data wiggling), then drop busy with the byte.
    // Returns inside the strobe cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_busy = 1'b1;
        bus.rx_data = 8'($urandom);
        @(negedge clk);
        bus.rx_data = 8'($urandom);
        @(negedge clk);
        bus.rx_data = rev8(b);
        bus.rx_busy = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_busy = 1'b0;
        bus.rx_data = 8'h00;
        nRESET      = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.digit_id !== 6'd0)  begin errors++; $display("FAIL reset_digit_id: got %0d expected 0", bus.digit_id); end
        checks++; if (bus.id_valid !== 1'b0)  begin errors++; $display("FAIL reset_id_valid: got %0b expected 0", bus.id_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", bus.frame_err); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count); end
        checks++; if (bus.state !== 2'd0)     begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        nRESET = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.state !== 2'd0)     begin errors++; $display("FAIL reset_idle_after_release: got %0d expected 0", bus.state); end
    endtask

    task automatic test_good_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5);
        @(negedge clk);
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL good_state_sync: got %0d expected 1", bus.state); end
        send_byte(8'h07);
        @(negedge clk);
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL good_state_id: got %0d expected 2", bus.state); end
        send_byte(8'hF8);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1)  begin errors++; $display("FAIL good_id_valid: got %0b expected 1", bus.id_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL good_no_err: got %0b expected 0", bus.frame_err); end
        checks++; if (bus.digit_id !== 6'd7)  begin errors++; $display("FAIL good_digit_id: got %0d expected 7", bus.digit_id); end
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0)  begin errors++; $display("FAIL good_valid_one_cycle: got %0b expected 0", bus.id_valid); end
        checks++; if (bus.state !== 2'd0)     begin errors++; $display("FAIL good_state_idle: got %0d expected 0", bus.state); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL good_err_count: got %0d expected 0", bus.err_count); end
        repeat (2) @(negedge clk);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL good_valid_pulses: got %0d expected 1", n_valid - v0); end
        checks++; if (n_err - e0 !== 0)   begin errors++; $display("FAIL good_err_pulses: got %0d expected 0", n_err - e0); end
    endtask

    task automatic test_bad_check();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'hF9);
        @(negedge clk);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL bad_frame_err: got %0b expected 1", bus.frame_err); end
        checks++; if (bus.id_valid !== 1'b0)  begin errors++; $display("FAIL bad_no_valid: got %0b expected 0", bus.id_valid); end
        @(negedge clk);
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL bad_err_one_cycle: got %0b expected 0", bus.frame_err); end
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL bad_err_count: got %0d expected 1", bus.err_count); end
        checks++; if (bus.digit_id !== 6'd7)  begin errors++; $display("FAIL bad_digit_held: got %0d expected 7", bus.digit_id); end
        checks++; if (bus.state !== 2'd0)     begin errors++; $display("FAIL bad_state: got %0d expected 0", bus.state); end
        repeat (2) @(negedge clk);
        checks++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin errors++; $display("FAIL bad_pulses: got err %0d valid %0d expected 1 0", n_err - e0, n_valid - v0); end
    endtask

    task automatic test_resync();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5);
        send_byte(8'hA5);
        @(negedge clk);
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL resync_state: got %0d expected 1", bus.state); end
        send_byte(8'h0C);
        send_byte(8'hF3);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1)  begin errors++; $display("FAIL resync_valid: got %0b expected 1", bus.id_valid); end
        checks++; if (bus.digit_id !== 6'd12) begin errors++; $display("FAIL resync_digit_id: got %0d expected 12", bus.digit_id); end
        repeat (2) @(negedge clk);
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL resync_err_count: got %0d expected 1", bus.err_count); end
        checks++; if (n_err - e0 !== 0 || n_valid - v0 !== 1) begin errors++; $display("FAIL resync_pulses: got err %0d valid %0d expected 0 1", n_err - e0, n_valid - v0); end
    endtask

    task automatic test_timeout();
        int e0;
        // Stall after SYNC: counter is 0 in cycle N+1 and reaches 15 in N+16.
        send_byte(8'hA5);
        repeat (16) @(posedge clk);
        #1;
        checks++; if (bus.frame_err !== 1'b0 || bus.state !== 2'd1) begin errors++; $display("FAIL tmo_early: got err %0b state %0d expected 0 1", bus.frame_err, bus.state); end
        @(posedge clk);
        #1;
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL tmo_frame_err: got %0b expected 1", bus.frame_err); end
        checks++; if (bus.state !== 2'd0)     begin errors++; $display("FAIL tmo_state: got %0d expected 0", bus.state); end
        checks++; if (bus.err_count !== 8'd2) begin errors++; $display("FAIL tmo_err_count: got %0d expected 2", bus.err_count); end
        @(posedge clk);
        #1;
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL tmo_err_one_cycle: got %0b expected 0", bus.frame_err); end

        // Byte strobed in cycle N+15: in time.
        e0 = n_err;
        send_byte(8'hA5);
        repeat (12) @(negedge clk);
        send_byte(8'h07);
        @(negedge clk);
        checks++; if (bus.state !== 2'd2 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL tmo_late_byte: got state %0d err %0b expected 2 0", bus.state, bus.frame_err); end
        // Check byte strobed in exactly the timeout cycle: the byte wins.
        repeat (12) @(negedge clk);
        send_byte(8'hF8);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL tmo_tie_byte_wins: got valid %0b err %0b expected 1 0", bus.id_valid, bus.frame_err); end
        repeat (2) @(negedge clk);
        checks++; if (bus.err_count !== 8'd2 || n_err - e0 !== 0) begin errors++; $display("FAIL tmo_no_extra_err: got count %0d pulses %0d expected 2 0", bus.err_count, n_err - e0); end
    endtask

    task automatic test_saturation();
        // err_count is 2; 256 more bad frames in total.
        for (int i = 0; i < 252; i++) begin
            send_byte(8'hA5);
            send_byte(8'h40);
        end
        repeat (2) @(negedge clk);
        checks++; if (bus.err_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", bus.err_count); end
        send_byte(8'hA5);
        send_byte(8'h40);
        repeat (2) @(negedge clk);
        checks++; if (bus.err_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", bus.err_count); end
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hA5);
            send_byte(8'h40);
        end
        @(negedge clk);
        checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL sat_err_pulse: got %0b expected 1", bus.frame_err); end
        checks++; if (bus.err_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", bus.err_count); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5);
        send_byte(8'h03);
        @(negedge clk);
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL rst_mid_pre_state: got %0d expected 2", bus.state); end
        // Assert between edges: outputs must clear without a clock edge.
        #2;
        nRESET = 1'b0;
        #1;
        checks++; if (bus.state !== 2'd0)     begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", bus.state); end
        checks++; if (bus.digit_id !== 6'd0)  begin errors++; $display("FAIL rst_mid_digit_id: got %0d expected 0", bus.digit_id); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL rst_mid_err_count: got %0d expected 0", bus.err_count); end
        @(negedge clk);
        nRESET = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hFC);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.digit_id !== 6'd3) begin errors++; $display("FAIL rst_mid_refresh: got valid %0b id %0d expected 1 3", bus.id_valid, bus.digit_id); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL rst_mid_after_count: got %0d expected 0", bus.err_count); end
    endtask

    task automatic test_id_range();
        send_byte(8'hA5);
        send_byte(8'h24);
        send_byte(8'hDB);
`ifdef ID_RANGE_CHECK_EN
        // 0x24 (36) is rejected already in the ID slot; DB is then noise.
        repeat (2) @(negedge clk);
        checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL range_err_count: got %0d expected 1", bus.err_count); end
        checks++; if (bus.digit_id !== 6'd3)  begin errors++; $display("FAIL range_digit_held: got %0d expected 3", bus.digit_id); end
`else
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.digit_id !== 6'd36) begin errors++; $display("FAIL range_accept_36: got valid %0b id %0d expected 1 36", bus.id_valid, bus.digit_id); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL range_err_count: got %0d expected 0", bus.err_count); end
`endif
        send_byte(8'hA5);
        send_byte(8'h23);
        send_byte(8'hDC);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.digit_id !== 6'd35) begin errors++; $display("FAIL range_accept_35: got valid %0b id %0d expected 1 35", bus.id_valid, bus.digit_id); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_good_frame();
        test_bad_check();
        test_resync();
        test_timeout();
        test_saturation();
        test_reset_midframe();
        test_id_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
